// File: rtl/pcie_phy_tx_framer.sv
// x4 Gen1/2 transmit framer: wraps AXIS packets in STP/SDP ... END framing with PAD fill.
// Define PHY_TX_SKP_EN to insert periodic SKP ordered sets between packets.
module pcie_phy_tx_framer #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH   = 3,
    parameter int unsigned SKP_INTERVAL = 1180
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  link_up_i,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tdatak,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  err_o
);

    localparam logic [7:0] K_STP = 8'hFB;
    localparam logic [7:0] K_SDP = 8'h5C;
    localparam logic [7:0] K_END = 8'hFD;
    localparam logic [7:0] K_PAD = 8'hF7;
    localparam logic [7:0] K_COM = 8'hBC;
    localparam logic [7:0] K_SKP = 8'h1C;

    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $error("pcie_phy_tx_framer supports DATA_WIDTH=32 only");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_TAIL = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_nxt_state;
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic [KEEP_WIDTH-1:0]   r_m_tdatak;
    logic                    r_m_tvalid;
    logic                    r_err;
    logic [7:0]              r_carry;
    logic                    r_carry_k;
    logic                    r_tail_full;
    logic                    r_run;

    logic [DATA_WIDTH-1:0]   w_nxt_tdata;
    logic [KEEP_WIDTH-1:0]   w_nxt_tdatak;
    logic                    w_nxt_tvalid;
    logic                    w_nxt_err;
    logic [7:0]              w_nxt_carry;
    logic                    w_nxt_carry_k;
    logic                    w_nxt_tail_full;
    logic                    w_skp_clr;
    logic                    w_skp_issue;

    logic                    w_load;
    logic                    w_s_tready;
    logic                    w_accept;
    logic                    w_keep_ok;
    logic [2:0]              w_keep_n;
    logic [2:0]              w_nbytes;
    logic                    w_err;
    logic [7:0]              w_lo;
    logic                    w_lo_k;
    logic [7:0]              w_in0;
    logic [7:0]              w_in1;
    logic [7:0]              w_in2;
    logic [7:0]              w_in3;
    logic                    w_unused_user;

    assign w_in0 = s_axis_tdata[7:0];
    assign w_in1 = s_axis_tdata[15:8];
    assign w_in2 = s_axis_tdata[23:16];
    assign w_in3 = s_axis_tdata[31:24];
    assign w_unused_user = ^s_axis_tuser;

    // r_run keeps tready low until the first clock after reset release
    assign w_load     = !r_m_tvalid || m_axis_tready;
    assign w_s_tready = r_run && link_up_i && (r_state != ST_TAIL) && !w_skp_issue && w_load;
    assign w_accept   = w_s_tready && s_axis_tvalid;

    always_comb begin
        w_keep_ok = 1'b1;
        w_keep_n  = 3'd4;
        case (s_axis_tkeep)
            4'b0001: w_keep_n = 3'd1;
            4'b0011: w_keep_n = 3'd2;
            4'b0111: w_keep_n = 3'd3;
            4'b1111: w_keep_n = 3'd4;
            default: w_keep_ok = 1'b0;
        endcase
    end

    // Malformed beats are flagged and then framed as full beats
    assign w_err    = !w_keep_ok || (!s_axis_tlast && (s_axis_tkeep != 4'hF));
    assign w_nbytes = (w_err || !s_axis_tlast) ? 3'd4 : w_keep_n;
    assign w_lo     = (r_state == ST_IDLE) ? (s_axis_tuser[0] ? K_SDP : K_STP) : r_carry;
    assign w_lo_k   = (r_state == ST_IDLE) ? 1'b1 : r_carry_k;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_tdata     = r_m_tdata;
        w_nxt_tdatak    = r_m_tdatak;
        w_nxt_tvalid    = r_m_tvalid && !m_axis_tready;
        w_nxt_err       = 1'b0;
        w_nxt_carry     = r_carry;
        w_nxt_carry_k   = r_carry_k;
        w_nxt_tail_full = r_tail_full;
        w_skp_clr       = 1'b0;
        unique case (r_state)
            ST_TAIL: begin
                if (w_load) begin
                    w_nxt_tvalid = 1'b1;
                    w_nxt_state  = ST_IDLE;
                    w_nxt_carry  = 8'h00;
                    if (r_tail_full) begin
                        w_nxt_tdata  = {K_PAD, K_PAD, K_END, r_carry};
                        w_nxt_tdatak = 4'b1110;
                    end else begin
                        w_nxt_tdata  = {K_PAD, K_PAD, K_PAD, K_END};
                        w_nxt_tdatak = 4'b1111;
                    end
                end
            end
            default: begin
                if (w_skp_issue && w_load) begin
                    w_nxt_tvalid = 1'b1;
                    w_nxt_tdata  = {K_SKP, K_SKP, K_SKP, K_COM};
                    w_nxt_tdatak = 4'b1111;
                    w_skp_clr    = 1'b1;
                end else if (w_accept) begin
                    w_nxt_tvalid  = 1'b1;
                    w_nxt_err     = w_err;
                    w_nxt_carry   = w_in3;
                    w_nxt_carry_k = 1'b0;
                    case (w_nbytes)
                        3'd1: begin
                            w_nxt_tdata  = {K_PAD, K_END, w_in0, w_lo};
                            w_nxt_tdatak = {3'b110, w_lo_k};
                            w_nxt_state  = ST_IDLE;
                        end
                        3'd2: begin
                            w_nxt_tdata  = {K_END, w_in1, w_in0, w_lo};
                            w_nxt_tdatak = {3'b100, w_lo_k};
                            w_nxt_state  = ST_IDLE;
                        end
                        3'd3: begin
                            w_nxt_tdata     = {w_in2, w_in1, w_in0, w_lo};
                            w_nxt_tdatak    = {3'b000, w_lo_k};
                            w_nxt_state     = ST_TAIL;
                            w_nxt_tail_full = 1'b0;
                        end
                        default: begin
                            w_nxt_tdata  = {w_in2, w_in1, w_in0, w_lo};
                            w_nxt_tdatak = {3'b000, w_lo_k};
                            if (s_axis_tlast) begin
                                w_nxt_state     = ST_TAIL;
                                w_nxt_tail_full = 1'b1;
                            end else begin
                                w_nxt_state = ST_DATA;
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_m_tdata   <= '0;
            r_m_tdatak  <= '0;
            r_m_tvalid  <= 1'b0;
            r_err       <= 1'b0;
            r_carry     <= 8'h00;
            r_carry_k   <= 1'b0;
            r_tail_full <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_m_tdata   <= w_nxt_tdata;
            r_m_tdatak  <= w_nxt_tdatak;
            r_m_tvalid  <= w_nxt_tvalid;
            r_err       <= w_nxt_err;
            r_carry     <= w_nxt_carry;
            r_carry_k   <= w_nxt_carry_k;
            r_tail_full <= w_nxt_tail_full;
            r_run       <= 1'b1;
        end
    end

`ifdef PHY_TX_SKP_EN
    localparam int unsigned SKP_CNT_W = 12;

    logic [SKP_CNT_W-1:0] r_skp_cnt;
    logic                 r_skp_pending;
    logic                 w_skp_set;

    assign w_skp_set   = link_up_i && (r_skp_cnt == SKP_CNT_W'(SKP_INTERVAL - 1));
    assign w_skp_issue = (r_state == ST_IDLE) && r_skp_pending && link_up_i && r_run;

    // Interval counter; a set while already pending simply merges
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_skp_cnt     <= '0;
            r_skp_pending <= 1'b0;
        end else begin
            if (!link_up_i || w_skp_set) begin
                r_skp_cnt <= '0;
            end else begin
                r_skp_cnt <= r_skp_cnt + SKP_CNT_W'(1);
            end
            r_skp_pending <= (r_skp_pending && !w_skp_clr) || w_skp_set;
        end
    end
`else
    logic w_unused_skp;

    assign w_skp_issue  = 1'b0;
    assign w_unused_skp = w_skp_clr ^ (SKP_INTERVAL != 0);
`endif

    assign s_axis_tready = w_s_tready;
    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tdatak = r_m_tdatak;
    assign m_axis_tvalid = r_m_tvalid;
    assign err_o         = r_err;

endmodule
